// File: rtl/rom_port_arbiter.sv
// Two-port (instruction fetch / load) arbiter in front of a combinational program ROM.
// Build option ROM_ARB_ROUND_ROBIN_EN: alternate simultaneous requests; otherwise IF has fixed priority.
module rom_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    typedef enum logic {ST_IDLE, ST_READ} state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    // Holds the current owner during READ and doubles as last_owner for arbitration.
    logic              r_last_owner, w_last_owner_next;
    logic              r_if_gnt, w_if_gnt_next;
    logic              r_ls_gnt, w_ls_gnt_next;
    logic              r_if_rvalid, w_if_rvalid_next;
    logic              r_ls_rvalid, w_ls_rvalid_next;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
    logic [DATA_W-1:0] r_ls_rdata, w_ls_rdata_next;

    logic              w_pick_ls;
    logic [ADDR_W-1:0] w_win_addr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    assign w_pick_ls = ls_req & (~if_req | (r_last_owner == OWN_IF));
`else
    assign w_pick_ls = ls_req & ~if_req;
`endif

    assign w_win_addr = w_pick_ls ? ls_addr : if_addr;

    always_comb begin
        w_state_next      = r_state;
        w_mem_addr_next   = r_mem_addr;
        w_last_owner_next = r_last_owner;
        w_if_gnt_next     = 1'b0;
        w_ls_gnt_next     = 1'b0;
        w_if_rvalid_next  = 1'b0;
        w_ls_rvalid_next  = 1'b0;
        w_if_rdata_next   = r_if_rdata;
        w_ls_rdata_next   = r_ls_rdata;
        case (r_state)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    w_state_next      = ST_READ;
                    w_mem_addr_next   = w_win_addr & ALIGN_MASK;
                    w_last_owner_next = w_pick_ls ? OWN_LS : OWN_IF;
                    w_ls_gnt_next     = w_pick_ls;
                    w_if_gnt_next     = ~w_pick_ls;
                end
            end
            ST_READ: begin
                // ROM is combinational, so mem_data already reflects r_mem_addr here.
                w_state_next = ST_IDLE;
                if (r_last_owner == OWN_LS) begin
                    w_ls_rvalid_next = 1'b1;
                    w_ls_rdata_next  = mem_data;
                end else begin
                    w_if_rvalid_next = 1'b1;
                    w_if_rdata_next  = mem_data;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mem_addr   <= '0;
            r_last_owner <= OWN_LS;
            r_if_gnt     <= 1'b0;
            r_ls_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_ls_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_mem_addr   <= w_mem_addr_next;
            r_last_owner <= w_last_owner_next;
            r_if_gnt     <= w_if_gnt_next;
            r_ls_gnt     <= w_ls_gnt_next;
            r_if_rvalid  <= w_if_rvalid_next;
            r_ls_rvalid  <= w_ls_rvalid_next;
            r_if_rdata   <= w_if_rdata_next;
            r_ls_rdata   <= w_ls_rdata_next;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign ls_gnt    = r_ls_gnt;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign mem_addr  = r_mem_addr;
    assign busy      = (r_state == ST_READ);

endmodule
